// File: rtl/display_scan_mux.sv
// Four-digit seven-segment scanner: walks active-low anodes and presents the matching nibble.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always lit).
module display_scan_mux #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        enable,
    output logic        pending,
    output logic        frame,
    output logic        w,
    output logic        x,
    output logic        y,
    output logic        z,
    output logic [3:0]  an
);
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] presc_reg, presc_next;
    logic [1:0]    idx_reg, idx_next;
    logic [15:0]   pend_reg, disp_reg, disp_next;
    logic          pend_flag;
    logic [3:0]    nib_reg, nib_next;
    logic [3:0]    an_reg, an_next;
    logic          frame_reg;
    logic          tc, wrap;
    logic [3:0]    blank;

    // blank[i] marks a digit whose nibble and every higher nibble are zero
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_blank
`ifdef LEADING_ZERO_BLANK_EN
            if (gi == 0) begin : g_d0
                assign blank[gi] = 1'b0;
            end else begin : g_dn
                assign blank[gi] = ~|disp_reg[15:4*gi];
            end
`else
            assign blank[gi] = 1'b0;
`endif
        end
    endgenerate

    always_comb begin
        tc         = enable && (presc_reg == PW'(REFRESH_DIV - 1));
        wrap       = tc && (idx_reg == 2'd3);
        presc_next = presc_reg;
        idx_next   = idx_reg;
        if (enable) begin
            presc_next = tc ? '0 : presc_reg + PW'(1);
            idx_next   = tc ? idx_reg + 2'd1 : idx_reg;
        end
        disp_next = (wrap && pend_flag) ? pend_reg : disp_reg;
        // nibble follows the pre-edge display value, so a commit shows up one cycle later
        nib_next  = disp_reg[{idx_next, 2'b00} +: 4];
        an_next   = enable ? (~(4'b0001 << idx_next) | blank) : 4'b1111;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
            idx_reg   <= 2'd0;
            pend_reg  <= 16'h0000;
            pend_flag <= 1'b0;
            disp_reg  <= 16'h0000;
            nib_reg   <= 4'h0;
            an_reg    <= 4'b1111;
            frame_reg <= 1'b0;
        end else begin
            presc_reg <= presc_next;
            idx_reg   <= idx_next;
            disp_reg  <= disp_next;
            nib_reg   <= nib_next;
            an_reg    <= an_next;
            frame_reg <= wrap;
            if (load) begin
                pend_reg  <= value;
                pend_flag <= 1'b1;
            end else if (wrap) begin
                pend_flag <= 1'b0;
            end
        end
    end

    assign pending = pend_flag;
    assign frame   = frame_reg;
    assign {w, x, y, z} = nib_reg;
    assign an      = an_reg;
endmodule

// File: tb/tb_display_scan_mux.sv
// Randomized scoreboard bench for display_scan_mux with a scan-time reference model.
`timescale 1ns/1ps
module tb_display_scan_mux;
    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'h0;
    logic        load = 1'b0;
    logic        enable = 1'b0;
    logic        pending, frame, w, x, y, z;
    logic [3:0]  an;

    display_scan_mux #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .enable(enable),
        .pending(pending), .frame(frame), .w(w), .x(x), .y(y), .z(z), .an(an)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] nib;
        logic       frame;
        logic       pend;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    // reference model: one scan-time counter over the whole frame
    int          scan_t = 0;
    logic [15:0] m_pend = 16'h0;
    logic [15:0] m_disp = 16'h0;
    logic        m_pflag = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_t e;
        scan_t = 0; m_pend = 16'h0; m_disp = 16'h0; m_pflag = 1'b0;
        e.an = 4'b1111; e.nib = 4'h0; e.frame = 1'b0; e.pend = 1'b0;
        sb.push_back(e);
    endtask

    // drive one cycle starting at a falling edge; push the response expected after the next rising edge
    task automatic step(input logic r, input logic en, input logic ld, input logic [15:0] v);
        exp_t e;
        int ns, dn;
        logic wr;
        logic [15:0] sh;
        rst = r; enable = en; load = ld; value = v;
        if (r) begin
            model_reset();
        end else begin
            ns = en ? (scan_t + 1) % FRAME : scan_t;
            wr = en && (scan_t == FRAME - 1);
            dn = ns / DIV;
            sh = m_disp >> (4 * dn);
            e.nib = sh[3:0];
            e.an = en ? ~(4'b0001 << dn) : 4'b1111;
`ifdef LEADING_ZERO_BLANK_EN
            if (en) for (int i = 1; i < 4; i++) if ((m_disp >> (4 * i)) == 16'h0) e.an[i] = 1'b1;
`endif
            e.frame = wr;
            e.pend = ld ? 1'b1 : (wr ? 1'b0 : m_pflag);
            sb.push_back(e);
            if (wr && m_pflag) m_disp = m_pend;
            if (ld) m_pend = v;
            m_pflag = e.pend;
            scan_t = ns;
        end
        $display("cycle t=%0t rst=%0b en=%0b load=%0b value=%h exp_an=%b exp_nib=%h exp_frame=%0b exp_pend=%0b",
                 $time, r, en, ld, v, e.an, e.nib, e.frame, e.pend);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < FRAME + 1 && scan_t != target; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
        chk("run_to_sync", scan_t, target);
    endtask

    // reset asserted mid-cycle must clear outputs before any clock edge
    task automatic async_rst();
        #2;
        rst = 1'b1; load = 1'b0;
        #1;
        chk("async_an", {28'h0, an}, {28'h0, 4'b1111});
        chk("async_pending", {31'h0, pending}, 32'h0);
        chk("async_nib", {28'h0, w, x, y, z}, 32'h0);
        model_reset();
        @(negedge clk);
    endtask

    // monitor: every rising edge presents a new registered output word
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("sb_empty", 32'h0, 32'h1);
            end else begin
                e = sb.pop_front();
                $display("check t=%0t an=%b nib=%b frame=%0b pend=%0b", $time, an, {w, x, y, z}, frame, pending);
                chk("an", {28'h0, an}, {28'h0, e.an});
                chk("nibble", {28'h0, w, x, y, z}, {28'h0, e.nib});
                chk("frame", {31'h0, frame}, {31'h0, e.frame});
                chk("pending", {31'h0, pending}, {31'h0, e.pend});
            end
        end
    end

    initial begin
        // reset held, then release with enable high
        step(1'b1, 1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0);
        idle(2);
        step(1'b0, 1'b1, 1'b1, 16'h1234);
        idle(2 * FRAME);
        // load on the wrap edge waits one more frame
        run_to(FRAME - 1);
        step(1'b0, 1'b1, 1'b1, 16'hABCD);
        idle(2 * FRAME + 3);
        // enable dropped mid digit 2, with a load accepted while dark
        run_to(2 * DIV + 1);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b1, 16'h0042);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        idle(2 * FRAME);
        // reset mid-frame with a pending value
        step(1'b0, 1'b1, 1'b1, 16'h9999);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        async_rst();
        step(1'b1, 1'b1, 1'b0, 16'h0);
        idle(FRAME);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic en, ld;
            logic [15:0] v;
            en = ($urandom_range(0, 7) != 0);
            ld = ($urandom_range(0, 9) == 0);
            v = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
            step(1'b0, en, ld, v);
        end
        step(1'b0, 1'b1, 1'b1, 16'h0042);
        idle(3 * FRAME);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
